// File: rtl/stage_pkg.sv
// Shared types for the stage sequencer: stage codes, branch conditions, flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage_pkg;

    // Pipeline stage code presented to the ALU; IDLE also reports FETCH.
    typedef enum logic [1:0] {
        STG_FETCH = 2'b00,
        STG_EXEC  = 2'b01,
        STG_MEM   = 2'b10,
        STG_WB    = 2'b11
    } stage_t;

    // Branch condition codes, evaluated against the stored flags in WB.
    typedef enum logic [2:0] {
        BR_NEVER  = 3'b000,
        BR_ALWAYS = 3'b001,
        BR_EQ     = 3'b010,
        BR_NE     = 3'b011,
        BR_GT     = 3'b100,
        BR_LT     = 3'b101,
        BR_C      = 3'b110,
        BR_Z      = 3'b111
    } br_cond_t;

    // Sequencer state: the low two bits are the stage code, bit 2 marks IDLE
    // so that IDLE reads back as stage 00.
    typedef enum logic [2:0] {
        ST_FETCH = {1'b0, STG_FETCH},
        ST_EXEC  = {1'b0, STG_EXEC},
        ST_MEM   = {1'b0, STG_MEM},
        ST_WB    = {1'b0, STG_WB},
        ST_IDLE  = 3'b100
    } state_t;

    // Bit positions inside the packed {c,eq,gt,lt,z} flag word.
    localparam int FLAG_W  = 5;
    localparam int FLAG_C  = 4;
    localparam int FLAG_EQ = 3;
    localparam int FLAG_GT = 2;
    localparam int FLAG_LT = 1;
    localparam int FLAG_Z  = 0;

    // Stage code seen by the ALU for a given sequencer state.
    function automatic stage_t state_to_stage(input state_t s);
        return stage_t'(s[1:0]);
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Stored ALU flags with carry feedback and branch-condition evaluation.
// Latency: flags load on the clock edge after load=1; branch_taken is combinational.
// Backpressure: none; load is a plain enable and the outputs are always valid.
module flag_reg
    import stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [FLAG_W-1:0]   flags_in,
    input  logic [2:0]          br_cond,
    input  logic                in_wb,
    output logic [FLAG_W-1:0]   flags,
    output logic                c_i,
    output logic                branch_taken
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              cond_true;

    // Next flag value: capture the ALU flags when asked, otherwise hold.
    always_comb begin
        flags_d = flags_q;
        if (load) begin
            flags_d = flags_in;
        end
    end

    // Flag storage, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Decode the branch condition against the stored flags; only WB may report a taken branch.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond_t'(br_cond))
            BR_NEVER:  cond_true = 1'b0;
            BR_ALWAYS: cond_true = 1'b1;
            BR_EQ:     cond_true = flags_q[FLAG_EQ];
            BR_NE:     cond_true = ~flags_q[FLAG_EQ];
            BR_GT:     cond_true = flags_q[FLAG_GT];
            BR_LT:     cond_true = flags_q[FLAG_LT];
            BR_C:      cond_true = flags_q[FLAG_C];
            BR_Z:      cond_true = flags_q[FLAG_Z];
            default:   cond_true = 1'b0;
        endcase
        branch_taken = in_wb & cond_true;
    end

    assign flags = flags_q;
    assign c_i   = flags_q[FLAG_C];

endmodule

// File: rtl/stage_seq.sv
// Instruction stage sequencer IDLE->FETCH->EXEC->MEM->WB with flag capture and branch decision.
// Latency: 4 cycles per instruction, plus one cycle for every cycle mem_busy holds MEM.
// Backpressure: mem_busy stalls in MEM only; start is ignored unless IDLE. Optional macro STAGE_SEQ_CYCLE_CNT_EN adds cycle_cnt.
module stage_seq
    import stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_i,
    input  logic        mem_busy,
    input  logic        flag_we,
    input  logic        c_o,
    input  logic        equal,
    input  logic        gt,
    input  logic        lt,
    input  logic        zero,
    input  logic [2:0]  br_cond,
    output logic [1:0]  stage,
    output logic        c_i,
    output logic [4:0]  flags,
    output logic        pc_en,
    output logic        reg_we,
    output logic        branch_taken,
    output logic        running,
`ifdef STAGE_SEQ_CYCLE_CNT_EN
    output logic [15:0] cycle_cnt,
`endif
    output logic        done
);

    state_t state_q;
    state_t state_d;
    logic   done_q;
    logic   done_d;
    logic   in_idle;
    logic   in_exec;
    logic   in_wb;
    logic   flag_load;
    logic [FLAG_W-1:0] alu_flags;

    assign in_idle = (state_q == ST_IDLE);
    assign in_exec = (state_q == ST_EXEC);
    assign in_wb   = (state_q == ST_WB);

    // Next-state logic: fixed single-cycle FETCH/EXEC, MEM waits on the memory, WB retires or halts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_FETCH;
            ST_FETCH:                state_d = ST_EXEC;
            ST_EXEC:                 state_d = ST_MEM;
            ST_MEM:   if (!mem_busy) state_d = ST_WB;
            ST_WB:    state_d = halt_i ? ST_IDLE : ST_FETCH;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Sticky halt indication: set when WB retires a halt, cleared when the next run starts.
    always_comb begin
        done_d = done_q;
        if (in_idle && start) begin
            done_d = 1'b0;
        end else if (in_wb && halt_i) begin
            done_d = 1'b1;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Strobes decode straight from the state so a reset drops them in the same instant.
    always_comb begin
        stage   = state_to_stage(state_q);
        running = ~in_idle;
        reg_we  = in_wb;
        pc_en   = in_wb & ~halt_i;
        done    = done_q;
    end

    // Flags are captured on the edge that leaves EXEC.
    assign flag_load = in_exec & flag_we;

    always_comb begin
        alu_flags          = '0;
        alu_flags[FLAG_C]  = c_o;
        alu_flags[FLAG_EQ] = equal;
        alu_flags[FLAG_GT] = gt;
        alu_flags[FLAG_LT] = lt;
        alu_flags[FLAG_Z]  = zero;
    end

    flag_reg u_flag_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (flag_load),
        .flags_in     (alu_flags),
        .br_cond      (br_cond),
        .in_wb        (in_wb),
        .flags        (flags),
        .c_i          (c_i),
        .branch_taken (branch_taken)
    );

`ifdef STAGE_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q;
    logic [15:0] cycle_cnt_d;

    // Free-running count of busy cycles; restarts from zero on each start out of IDLE.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (!in_idle) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end else if (start) begin
            cycle_cnt_d = 16'd0;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= 16'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_stage_seq.sv
// Directed bench for stage_seq: per-cycle comparison against a behavioural model plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_stage_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        halt_i = 1'b0;
    logic        mem_busy = 1'b0;
    logic        flag_we = 1'b0;
    logic        c_o = 1'b0;
    logic        equal = 1'b0;
    logic        gt = 1'b0;
    logic        lt = 1'b0;
    logic        zero = 1'b0;
    logic [2:0]  br_cond = 3'b000;
    logic [1:0]  stage;
    logic        c_i;
    logic [4:0]  flags;
    logic        pc_en;
    logic        reg_we;
    logic        branch_taken;
    logic        running;
    logic        done;
`ifdef STAGE_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    stage_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .halt_i       (halt_i),
        .mem_busy     (mem_busy),
        .flag_we      (flag_we),
        .c_o          (c_o),
        .equal        (equal),
        .gt           (gt),
        .lt           (lt),
        .zero         (zero),
        .br_cond      (br_cond),
        .stage        (stage),
        .c_i          (c_i),
        .flags        (flags),
        .pc_en        (pc_en),
        .reg_we       (reg_we),
        .branch_taken (branch_taken),
        .running      (running),
`ifdef STAGE_SEQ_CYCLE_CNT_EN
        .cycle_cnt    (cycle_cnt),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: an instruction is a walk through four numbered steps,
    // step 2 repeats while memory is busy, step 3 either loops back or stops the run.
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    int          m_pos = 0;
    bit          m_c = 1'b0, m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0, m_z = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_done = 1'b0; m_pos = 0; m_cnt = 16'd0;
            m_c = 1'b0; m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0; m_z = 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1'b1; m_pos = 0; m_done = 1'b0; m_cnt = 16'd0;
            end
        end else begin
            m_cnt = m_cnt + 16'd1;
            if (m_pos == 1 && flag_we) begin
                m_c = c_o; m_eq = equal; m_gt = gt; m_lt = lt; m_z = zero;
            end
            if (m_pos == 2 && mem_busy) begin
                m_pos = 2;
            end else if (m_pos == 3 && halt_i) begin
                m_run = 1'b0; m_done = 1'b1;
            end else begin
                m_pos = (m_pos + 1) % 4;
            end
        end
    end

    function automatic bit model_branch(input logic [2:0] cond);
        case (cond)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return m_eq;
            3'd3: return !m_eq;
            3'd4: return m_gt;
            3'd5: return m_lt;
            3'd6: return m_c;
            default: return m_z;
        endcase
    endfunction

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit in_wb;
            in_wb = m_run && (m_pos == 3);
            check("stage",   {14'd0, stage},   m_run ? 16'(m_pos) : 16'd0);
            check("running", {15'd0, running}, {15'd0, m_run});
            check("done",    {15'd0, done},    {15'd0, m_done});
            check("flags",   {11'd0, flags},   {11'd0, m_c, m_eq, m_gt, m_lt, m_z});
            check("c_i",     {15'd0, c_i},     {15'd0, m_c});
            check("reg_we",  {15'd0, reg_we},  {15'd0, in_wb});
            check("pc_en",   {15'd0, pc_en},   {15'd0, in_wb && !halt_i});
            check("branch",  {15'd0, branch_taken}, {15'd0, in_wb && model_branch(br_cond)});
`ifdef STAGE_SEQ_CYCLE_CNT_EN
            check("cycle_cnt", cycle_cnt, m_cnt);
`endif
        end
    end

    initial begin
        logic [1:0] s1_exp [5];
        int rw;
        s1_exp[0] = 2'd0; s1_exp[1] = 2'd1; s1_exp[2] = 2'd2; s1_exp[3] = 2'd3; s1_exp[4] = 2'd0;

        // Reset state
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stage",   {14'd0, stage}, 16'd0);
        check("rst_flags",   {11'd0, flags}, 16'd0);
        check("rst_c_i",     {15'd0, c_i}, 16'd0);
        check("rst_running", {15'd0, running}, 16'd0);
        check("rst_done",    {15'd0, done}, 16'd0);
        check("rst_strobes", {14'd0, pc_en, reg_we}, 16'd0);
        rst_n = 1'b1;
        tick;
        check("idle_hold", {15'd0, running}, 16'd0);

        // Plain instruction, no stalls; a start while running must be ignored
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("s1_stage", {14'd0, stage}, {14'd0, s1_exp[i]});
            check("s1_pc_en", {15'd0, pc_en}, (i == 3) ? 16'd1 : 16'd0);
            start = (i == 1);
            if (i < 4) tick;
        end
        start = 1'b0;

        // Flag capture at end of EXEC, then branch evaluation in WB
        tick;
        c_o = 1'b1; zero = 1'b1; flag_we = 1'b1;
        tick;
        c_o = 1'b0; zero = 1'b0; flag_we = 1'b0;
        check("s2_flags", {11'd0, flags}, 16'h0011);
        check("s2_c_i",   {15'd0, c_i}, 16'd1);
        br_cond = 3'b111;
        tick;
        check("s2_stage_wb", {14'd0, stage}, 16'd3);
        check("s2_br_z",  {15'd0, branch_taken}, 16'd1);
        br_cond = 3'b010;
        #1 check("s2_br_eq", {15'd0, branch_taken}, 16'd0);
        br_cond = 3'b011;
        #1 check("s2_br_ne", {15'd0, branch_taken}, 16'd1);
        br_cond = 3'b001;
        tick;
        check("s2_br_not_wb", {15'd0, branch_taken}, 16'd0);
        check("s2_flags_hold", {11'd0, flags}, 16'h0011);
        br_cond = 3'b000;

        // Three-cycle MEM stall; mem_busy outside MEM has no effect
        tick;
        mem_busy = 1'b1;
        tick;
        rw = 0;
        for (int k = 0; k < 4; k++) begin
            check("s3_stall_stage", {14'd0, stage}, 16'd2);
            rw += int'(reg_we);
            if (k == 3) mem_busy = 1'b0;
            tick;
        end
        check("s3_wb_late", {14'd0, stage}, 16'd3);
        rw += int'(reg_we);
        mem_busy = 1'b1;
        tick;
        check("s3_after_wb", {14'd0, stage}, 16'd0);
        rw += int'(reg_we);
        mem_busy = 1'b0;
        tick;
        rw += int'(reg_we);
        check("s3_reg_we_once", 16'(rw), 16'd1);

        // Halt in WB, start in the same cycle loses
        tick;
        tick;
        halt_i = 1'b1; start = 1'b1;
        #1;
        check("s4_pc_en_halt", {15'd0, pc_en}, 16'd0);
        check("s4_reg_we_halt", {15'd0, reg_we}, 16'd1);
        tick;
        halt_i = 1'b0; start = 1'b0;
        check("s4_idle_stage", {14'd0, stage}, 16'd0);
        check("s4_running", {15'd0, running}, 16'd0);
        check("s4_done", {15'd0, done}, 16'd1);
        tick;
        check("s4_done_hold", {15'd0, done}, 16'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("s4_done_clr", {15'd0, done}, 16'd0);
        check("s4_restart", {15'd0, running}, 16'd1);

        // Reset during a MEM stall
        tick;
        flag_we = 1'b1; c_o = 1'b1; gt = 1'b1;
        tick;
        flag_we = 1'b0; c_o = 1'b0; gt = 1'b0; mem_busy = 1'b1;
        check("s5_flags", {11'd0, flags}, 16'h0014);
        tick;
        #2 rst_n = 1'b0;
        #1;
        check("s5_stage", {14'd0, stage}, 16'd0);
        check("s5_flags_clr", {11'd0, flags}, 16'd0);
        check("s5_c_i", {15'd0, c_i}, 16'd0);
        check("s5_running", {15'd0, running}, 16'd0);
        check("s5_strobes", {14'd0, pc_en, reg_we}, 16'd0);
        rw = 0;
        repeat (2) begin tick; rw += int'(reg_we); end
        mem_busy = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin tick; rw += int'(reg_we); end
        check("s5_no_reg_we", 16'(rw), 16'd0);
        check("s5_idle", {15'd0, running}, 16'd0);

`ifdef STAGE_SEQ_CYCLE_CNT_EN
        // Counter wrap over 65537 running cycles
        start = 1'b1;
        tick;
        start = 1'b0;
        check("cnt_start", cycle_cnt, 16'd0);
        repeat (65537) tick;
        check("cnt_wrap", cycle_cnt, 16'd1);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
